// File: rtl/uart_axi_slave.sv
// rtl/uart_axi_slave.sv - AXI4-Lite register slave bridging byte TX/RX streams through FIFOs
//
// Register map (ADDR[3:2]):
//   0 RX data  (read pops one byte, zero-extended)
//   1 TX data  (write pushes WDATA[7:0] when WSTRB[0] is set)
//   2 status   {27'b0, overrun, tx_full, tx_empty, rx_full, rx_nonempty}
//   3 control  WDATA[0] flush TX, WDATA[1] flush RX, WDATA[4] clear overrun
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   AR*/R*                    AXI4-Lite read address / read data channels
//   AW*/W*/B*                 AXI4-Lite write address / data / response channels
//   TX_DATA/TX_VALID/TX_READY byte stream draining the TX FIFO
//   RX_DATA/RX_VALID/RX_READY byte stream filling the RX FIFO
//
// Parameter FIFO_DEPTH: entries per byte FIFO, power of two in 2..256.
// Macro UART_AXI_SLAVE_SLVERR_EN: when defined, illegal accesses answer SLVERR.

module uart_axi_slave #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ACK  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_TXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef UART_AXI_SLAVE_SLVERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

    // ------------------------------------------------------------------
    // State and FIFO declarations
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       r_addr;
    logic [31:0]      rd_data;
    logic [1:0]       rd_resp;

    logic [1:0]       w_state;
    logic [1:0]       w_addr;
    logic [7:0]       w_byte;
    logic             w_strb0;
    logic [1:0]       wr_resp;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr;
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_flush;

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W-1:0] rx_rd_ptr;
    logic [CNT_W-1:0] rx_count;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_flush;

    logic             overrun;
    logic             ovr_clr;
    logic             rd_hs;
    logic             wr_hs;
    logic             ctrl_wr;

    // Only byte lane 0 and the word-select address bits carry meaning.
    logic unused_inputs;
    assign unused_inputs = ^{WDATA[31:8], WSTRB[3:1], ARADDR[1:0], AWADDR[1:0]};

    // ------------------------------------------------------------------
    // Handshake strobes and FIFO control
    // ------------------------------------------------------------------
    // ARREADY and AWREADY/WREADY are each high for the single ACK cycle,
    // so that cycle is the handshake cycle for side effects.
    assign rd_hs   = (r_state == R_ACK);
    assign wr_hs   = (w_state == W_ACK);
    assign ctrl_wr = wr_hs && (w_addr == A_CTRL);

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);

    assign tx_push  = wr_hs && (w_addr == A_TXDATA) && w_strb0 && !tx_full;
    assign tx_pop   = TX_VALID && TX_READY;
    assign rx_push  = RX_VALID && RX_READY;
    assign rx_pop   = rd_hs && (r_addr == A_RXDATA) && !rx_empty;

    // Flushes are applied at the end of the handshake cycle, so the FIFO
    // reads as empty from the following cycle and beats any coincident
    // push or pop.
    assign tx_flush = ctrl_wr && w_byte[0];
    assign rx_flush = ctrl_wr && w_byte[1];
    assign ovr_clr  = ctrl_wr && w_byte[4];

    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_mem[tx_rd_ptr];
    assign RX_READY = !rx_full;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= w_byte;
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= RX_DATA;
    end

    // Overrun: a byte offered while RX is full. Clearing takes priority
    // over a simultaneous new overrun event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun <= 1'b0;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end else if (RX_VALID && rx_full) begin
            overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Read data is computed from the state seen in the handshake cycle and
    // captured into RDATA, where it stays stable through R_DATA.
    always_comb begin
        rd_data = 32'h0;
        case (r_addr)
            A_RXDATA: if (!rx_empty) rd_data = {24'h0, rx_mem[rx_rd_ptr]};
            A_STATUS: rd_data = {27'h0, overrun, tx_full, tx_empty, rx_full, !rx_empty};
            default:  rd_data = 32'h0;
        endcase
    end

`ifdef UART_AXI_SLAVE_SLVERR_EN
    always_comb begin
        rd_resp = RESP_OKAY;
        if (r_addr == A_TXDATA) begin
            rd_resp = RESP_SLVERR;
        end else if ((r_addr == A_RXDATA) && rx_empty) begin
            rd_resp = RESP_SLVERR;
        end
    end
`else
    assign rd_resp = RESP_OKAY;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= R_IDLE;
            r_addr  <= 2'd0;
            RDATA   <= 32'h0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_state <= R_ACK;
                        r_addr  <= ARADDR[3:2];
                    end
                end
                R_ACK: begin
                    r_state <= R_DATA;
                    RDATA   <= rd_data;
                    RRESP   <= rd_resp;
                end
                R_DATA: begin
                    if (RREADY) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign ARREADY = (r_state == R_ACK);
    assign RVALID  = (r_state == R_DATA);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
`ifdef UART_AXI_SLAVE_SLVERR_EN
    always_comb begin
        wr_resp = RESP_OKAY;
        if ((w_addr == A_RXDATA) || (w_addr == A_STATUS)) begin
            wr_resp = RESP_SLVERR;
        end else if ((w_addr == A_TXDATA) && tx_full) begin
            wr_resp = RESP_SLVERR;
        end
    end
`else
    assign wr_resp = RESP_OKAY;
`endif

    // Address and data are captured together once both valids are seen,
    // regardless of which arrived first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= W_IDLE;
            w_addr  <= 2'd0;
            w_byte  <= 8'h0;
            w_strb0 <= 1'b0;
            BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && WVALID) begin
                        w_state <= W_ACK;
                        w_addr  <= AWADDR[3:2];
                        w_byte  <= WDATA[7:0];
                        w_strb0 <= WSTRB[0];
                    end
                end
                W_ACK: begin
                    w_state <= W_RESP;
                    BRESP   <= wr_resp;
                end
                W_RESP: begin
                    if (BREADY) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign AWREADY = (w_state == W_ACK);
    assign WREADY  = (w_state == W_ACK);
    assign BVALID  = (w_state == W_RESP);

endmodule
